// File: rtl/tx_frame_upsampler.sv
// Framed I/Q symbol mapper with zero-insertion upsampling (preamble/payload/guard).
// Define TX_PREAMBLE_EN to include the alternating preamble section.
`timescale 1ns/1ps
module tx_frame_upsampler #(
  parameter int SPS          = 4,
  parameter int SAMPLE_W     = 12,
  parameter int PREAMBLE_LEN = 16,
  parameter int PAYLOAD_LEN  = 256,
  parameter int GUARD_LEN    = 9,
  parameter int AMP_OUTER    = 948,
  parameter int AMP_INNER    = 316,
  parameter int AMP_QPSK     = 724
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       start,
  input  logic                       mode,
  input  logic [3:0]                 bits_in,
  input  logic                       bits_valid,
  output logic                       bits_ready,
  output logic signed [SAMPLE_W-1:0] up_I,
  output logic signed [SAMPLE_W-1:0] up_Q,
  output logic                       up_valid,
  output logic                       sym_tick,
  output logic                       busy,
  output logic                       frame_start,
  output logic                       frame_done,
  output logic                       underrun
);

  localparam int PW = $clog2(SPS);
  localparam logic signed [SAMPLE_W-1:0] AO = SAMPLE_W'(AMP_OUTER);
  localparam logic signed [SAMPLE_W-1:0] AI = SAMPLE_W'(AMP_INNER);
  localparam logic signed [SAMPLE_W-1:0] AQ = SAMPLE_W'(AMP_QPSK);

  if (SPS < 2 || SPS > 16 || (SPS & (SPS - 1)) != 0) begin : g_bad_sps
    $error("SPS must be a power of two in 2..16");
  end
  if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 255) begin : g_bad_pre
    $error("PREAMBLE_LEN out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
`ifdef TX_PREAMBLE_EN
    PREAMBLE,
`endif
    PAYLOAD,
    GUARD
  } state_t;

`ifdef TX_PREAMBLE_EN
  localparam state_t FIRST = PREAMBLE;
`else
  localparam state_t FIRST = PAYLOAD;
`endif

  state_t          state, cur_st, nx_st;
  logic [PW-1:0]   phase, cur_ph, nx_ph;
  logic [15:0]     cnt, cur_cnt, nx_cnt;
  logic            mode_q, cur_mode;
  logic            accept, emit, tick, under, done;
  logic signed [SAMPLE_W-1:0] s_i, s_q;

  function automatic logic signed [SAMPLE_W-1:0] qam(input logic [1:0] b);
    logic signed [SAMPLE_W-1:0] r;
    unique case (b)
      2'b00:   r = -AO;
      2'b01:   r = -AI;
      2'b11:   r = AI;
      default: r = AO;
    endcase
    return r;
  endfunction

  // busy stays high through the frame_done sample, which also blocks a
  // coincident start from being accepted.
  assign accept = en && start && (state == IDLE) && !busy;

  always_comb begin
    cur_st   = state;
    cur_ph   = phase;
    cur_cnt  = cnt;
    cur_mode = mode_q;
    if (accept) begin
      cur_st   = FIRST;
      cur_ph   = '0;
      cur_cnt  = '0;
      cur_mode = mode;
    end
    emit  = en && (cur_st != IDLE);
    tick  = (cur_ph == '0);
    under = 1'b0;
    s_i   = '0;
    s_q   = '0;
    unique case (cur_st)
`ifdef TX_PREAMBLE_EN
      PREAMBLE: if (tick) begin
        s_i = cur_cnt[0] ? -AO : AO;
        s_q = cur_cnt[0] ? -AO : AO;
      end
`endif
      PAYLOAD: if (tick) begin
        if (!bits_valid) under = 1'b1;
        else if (cur_mode) begin
          s_i = bits_in[1] ? AQ : -AQ;
          s_q = bits_in[0] ? AQ : -AQ;
        end else begin
          s_i = qam(bits_in[3:2]);
          s_q = qam(bits_in[1:0]);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    nx_st  = cur_st;
    nx_ph  = cur_ph + 1'b1;
    nx_cnt = cur_cnt;
    done   = 1'b0;
    if (cur_ph == PW'(SPS - 1)) begin
      nx_ph  = '0;
      nx_cnt = cur_cnt + 16'd1;
      unique case (cur_st)
`ifdef TX_PREAMBLE_EN
        PREAMBLE: if (cur_cnt == 16'(PREAMBLE_LEN - 1)) begin
          nx_st  = PAYLOAD;
          nx_cnt = '0;
        end
`endif
        PAYLOAD: if (cur_cnt == 16'(PAYLOAD_LEN - 1)) begin
          nx_cnt = '0;
          if (GUARD_LEN == 0) begin
            nx_st = IDLE;
            done  = 1'b1;
          end else begin
            nx_st = GUARD;
          end
        end
        GUARD: if (cur_cnt == 16'(GUARD_LEN - 1)) begin
          nx_st  = IDLE;
          nx_cnt = '0;
          done   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bits_ready = emit && (cur_st == PAYLOAD) && tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase       <= '0;
      cnt         <= '0;
      mode_q      <= 1'b0;
      up_I        <= '0;
      up_Q        <= '0;
      up_valid    <= 1'b0;
      sym_tick    <= 1'b0;
      busy        <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
    end else if (!en) begin
      up_valid    <= 1'b0;
      sym_tick    <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      up_valid    <= emit;
      up_I        <= emit ? s_i : '0;
      up_Q        <= emit ? s_q : '0;
      sym_tick    <= emit && tick;
      busy        <= emit;
      frame_start <= accept;
      frame_done  <= emit && done;
      underrun    <= emit && under;
      if (emit) begin
        state  <= nx_st;
        phase  <= nx_ph;
        cnt    <= nx_cnt;
        mode_q <= cur_mode;
      end
    end
  end

endmodule

// File: doc/tx_frame_upsampler.md
TX_FRAME_UPSAMPLER -- requirements
Module: tx_frame_upsampler

Interface
REQ-001 SHALL have parameter SPS, default 4, samples per symbol (power of two, 2..16).
REQ-002 SHALL have parameter SAMPLE_W, default 12, signed I/Q output width (Q1.(SAMPLE_W-1)).
REQ-003 SHALL have parameter PREAMBLE_LEN, default 16, preamble symbols per frame (1..255).
REQ-004 SHALL have parameter PAYLOAD_LEN, default 256, payload symbols per frame (1..65535).
REQ-005 SHALL have parameter GUARD_LEN, default 9, zero-symbol tail per frame, flushes downstream RRC (0..255).
REQ-006 SHALL have parameters AMP_OUTER, AMP_INNER, AMP_QPSK, defaults 948, 316, 724, signed constellation levels.
REQ-007 clk  input  1  sole clock; all state on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 en  input  1  sample-rate enable; low freezes all state.
REQ-010 start  input  1  frame request, sampled only in IDLE.
REQ-011 mode  input  1  0 = 16-QAM, 1 = QPSK; latched at accepted start.
REQ-012 bits_in  input  4  payload bits, MSB first; QPSK uses bits_in[1:0].
REQ-013 bits_valid  input  1  bits_in valid.
REQ-014 bits_ready  output  1  symbol-fetch strobe; bits consumed when bits_valid && bits_ready.
REQ-015 up_I, up_Q  output  SAMPLE_W each  zero-inserted impulse-train samples.
REQ-016 up_valid  output  1  sample valid.
REQ-017 sym_tick  output  1  pulse coincident with each symbol-bearing sample.
REQ-018 busy  output  1  high when state != IDLE.
REQ-019 frame_start, frame_done, underrun  output  1 each  single-cycle event pulses.

Function
REQ-020 FSM states IDLE, PREAMBLE, PAYLOAD, GUARD; symbol counter and phase counter 0..SPS-1 advance only when en=1.
REQ-021 IDLE: start=1 && en=1 -> PREAMBLE, phase 0, symbol count 0, mode latched; start ignored in all other states.
REQ-022 Outputs registered: first sample (preamble symbol 0) on cycle after accepted start, with frame_start=1 and sym_tick=1.
REQ-023 Phase 0 outputs symbol value, up_valid=1, sym_tick=1; phases 1..SPS-1 output 0/0 with up_valid=1, sym_tick=0.
REQ-024 PREAMBLE symbol k: even k -> (+AMP_OUTER,+AMP_OUTER), odd k -> (-AMP_OUTER,-AMP_OUTER); after PREAMBLE_LEN symbols -> PAYLOAD.
REQ-025 16-QAM Gray map per axis (I from bits[3:2], Q from bits[1:0]): 00 -> -AMP_OUTER, 01 -> -AMP_INNER, 11 -> +AMP_INNER, 10 -> +AMP_OUTER.
REQ-026 QPSK map: bit 1 -> I, bit 0 -> Q; 0 -> -AMP_QPSK, 1 -> +AMP_QPSK.
REQ-027 bits_ready=1 combinationally only in PAYLOAD at phase 0 boundary (cycle preceding symbol sample) with en=1.
REQ-028 bits_valid=0 at fetch: symbol emitted as 0/0, underrun pulses, symbol count still advances (frame length fixed).
REQ-029 After PAYLOAD_LEN symbols -> GUARD; GUARD emits GUARD_LEN*SPS zero samples, up_valid=1, sym_tick=1 at each phase 0.
REQ-030 frame_done pulses with last GUARD sample (last payload sample if GUARD_LEN=0); next cycle IDLE.
REQ-031 start coincident with frame_done ignored; new frame requires start in IDLE.
REQ-032 IDLE: up_valid=0, up_I=up_Q=0, sym_tick=0, bits_ready=0.
REQ-033 en=0: up_valid=0, sym_tick=0, bits_ready=0, event pulses 0, up_I/up_Q hold; resumes at same phase.
REQ-034 Frame length = (PREAMBLE_LEN+PAYLOAD_LEN+GUARD_LEN)*SPS enabled cycles exactly.

Reset
REQ-035 rst_n low: state IDLE, counters 0, all outputs 0, latched mode 0, immediately and regardless of clk.
REQ-036 Reset mid-frame abandons frame; no frame_done; next frame starts with preamble symbol 0.

Configuration
REQ-037 Macro TX_PREAMBLE_EN defined: PREAMBLE state present per REQ-024.
REQ-038 TX_PREAMBLE_EN undefined: PREAMBLE state, PREAMBLE_LEN logic removed; accepted start -> PAYLOAD, first sample is payload symbol 0, bits_ready asserted in start-accept cycle.

Verification
REQ-039 Defaults, TX_PREAMBLE_EN, start, bits_valid=1 constant -> busy for 1124 cycles, frame_start at cycle 1, frame_done at cycle 1124, 281 sym_ticks.
REQ-040 mode=0, bits_in=4'b1001 -> payload samples (+948,-316) at phase 0, (0,0) phases 1-3.
REQ-041 mode=1, bits_in=4'b0010 -> payload samples (+724,-724); mode toggled mid-frame -> no change.
REQ-042 bits_valid low for payload symbol 10 -> one underrun pulse, symbol (0,0), frame_done timing unchanged.
REQ-043 en held low 7 cycles mid-payload -> no up_valid during gap, sample sequence resumes unbroken, frame_done delayed 7 cycles.
REQ-044 rst_n asserted mid-PAYLOAD -> outputs 0 asynchronously, busy=0; subsequent start yields preamble (+948,+948) first.
